multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS-style datapath. Replaces single-cycle decode with an FSM that shares one ALU and one unified memory port across FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives PC/IR enables, datapath mux selects, memory strobes and the 4-bit ALU op. Waits on a memory ready handshake and counts retired instructions.

Parameters:
- OPCODE_W, 6, opcode width.
- ALU_OP_W, 4, ALU control width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero/condition
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- ir_write  out  1  IR load
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_to_reg  out  1  writeback: 0 ALUOut, 1 MDR
- reg_dst  out  1  destination: 0 rt, 1 rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  ALU_OP_W  ALU control code
- instr_retired  out  CNT_W  retired instruction count
- illegal_op  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (async, rst_n=0): state=INIT, op_q=0, instr_retired=0, illegal_op=0. All control outputs 0 while in INIT.
- INIT: all outputs 0 → FETCH next cycle. Also the recovery point for reset asserted mid-instruction; no partial write survives.
- Outputs: Moore decode of state and op_q. Exception: pc_write and ir_write in FETCH are gated by mem_ready.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0000.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_source=00, then → DECODE.
- DECODE:
  - op_q←opcode.
  - alu_src_a=0, alu_src_b=11, alu_op=0000 (branch target precompute).
  - Next state by opcode:
    - lw 100011, sw 101011 → MEM_ADDR
    - R 000000, bitswap 011111 → EXEC_R
    - addi 001000, addiu 001001, andi 001100, ori 001101, xori 001110, slti 001010, sltiu 001011, lui 001111 → EXEC_I
    - b 000011, beq 000100, bgez 000001, bne 000101 → BRANCH
    - j 000010 → JUMP
    - other → see Optional Feature
- ALU op codes by opcode:
  - R 0010, lui 1001, bitswap 1111
  - lw/sw/addi/addiu 0000
  - andi 0100, ori 0101, xori 0111, slti/sltiu 0110
  - b 1000, beq 0001, bgez 0011, bne 1011
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0000 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: i_or_d=1, mem_read=1; holds until mem_ready → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: i_or_d=1, mem_write=1; holds until mem_ready → FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op per table → ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op per table → ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R/bitswap, else 0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op per table, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- Instruction latency in cycles, with zero memory wait:
  - lw 5, sw 4, R/I-type 4, branch/jump 3.
  - Each memory wait cycle adds 1.
- instr_retired:
  - Increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, ALU_WB, BRANCH or JUMP.
  - Wraps modulo 2^CNT_W.
- mem_read and mem_write are never both 1. reg_write is never 1 in a memory-wait cycle.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in DECODE → HALT. In HALT, all outputs are 0, illegal_op=1 (sticky), and the block stays there until rst_n.
- Undefined: an unlisted opcode is a NOP (DECODE → FETCH), is counted as retired, and illegal_op is tied to 0.

Decomposition:
- Shared package uc_pkg holds:
  - opcode localparams
  - ALU op code localparams
  - alu_src_b and pc_source encodings
  - FSM state encoding
- One sub-module, alu_op_decode: combinational op_q → {alu_op, instruction class}. It is reused by the FSM for EXEC/BRANCH.

Test Plan:
- Reset release, then addi (001000) with mem_ready=1 → INIT, FETCH, DECODE, EXEC_I (alu_op=0000, alu_src_b=10), ALU_WB (reg_write=1, reg_dst=0); instr_retired=1.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEM_RD → mem_read held and ir_write pulses once; MEM_WB has mem_to_reg=1; 10 cycles from FETCH entry to next FETCH.
- sw then beq (000100) → MEM_WR mem_write=1 and reg_write=0; BRANCH alu_op=0001, pc_write_cond=1, pc_source=01.
- j (000010) → JUMP pc_write=1, pc_source=10; 3 cycles total; instr_retired increments.
- rst_n pulsed low during MEM_WR → outputs 0 immediately, mem_write drops asynchronously, counter=0, restart from INIT.
- Opcode 111111: with the macro → HALT, illegal_op=1, no further pc_write. Without it → back to FETCH, instr_retired+1.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU control codes,
// datapath mux selects, FSM states and the instruction classes used for dispatch.
package uc_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_BGEZ    = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_B       = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_BITSWAP = 6'b011111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_BEQ     = 4'b0001;
    localparam logic [3:0] ALU_RTYPE   = 4'b0010;
    localparam logic [3:0] ALU_BGEZ    = 4'b0011;
    localparam logic [3:0] ALU_AND     = 4'b0100;
    localparam logic [3:0] ALU_OR      = 4'b0101;
    localparam logic [3:0] ALU_SLT     = 4'b0110;
    localparam logic [3:0] ALU_XOR     = 4'b0111;
    localparam logic [3:0] ALU_B       = 4'b1000;
    localparam logic [3:0] ALU_LUI     = 4'b1001;
    localparam logic [3:0] ALU_BNE     = 4'b1011;
    localparam logic [3:0] ALU_BITSWAP = 4'b1111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_R,
        CLS_I,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } cls_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: maps an opcode to its ALU control code and the
// instruction class the sequencer dispatches on.
module alu_op_decode
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 4
) (
    input  logic [OPCODE_W-1:0] op_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output cls_e                cls_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        cls_o    = CLS_ILLEGAL;
        case (op_i)
            OP_RTYPE:   begin alu_op_o = ALU_RTYPE;   cls_o = CLS_R;      end
            OP_BITSWAP: begin alu_op_o = ALU_BITSWAP; cls_o = CLS_R;      end
            OP_LW:      begin alu_op_o = ALU_ADD;     cls_o = CLS_LOAD;   end
            OP_SW:      begin alu_op_o = ALU_ADD;     cls_o = CLS_STORE;  end
            OP_ADDI:    begin alu_op_o = ALU_ADD;     cls_o = CLS_I;      end
            OP_ADDIU:   begin alu_op_o = ALU_ADD;     cls_o = CLS_I;      end
            OP_ANDI:    begin alu_op_o = ALU_AND;     cls_o = CLS_I;      end
            OP_ORI:     begin alu_op_o = ALU_OR;      cls_o = CLS_I;      end
            OP_XORI:    begin alu_op_o = ALU_XOR;     cls_o = CLS_I;      end
            OP_SLTI:    begin alu_op_o = ALU_SLT;     cls_o = CLS_I;      end
            OP_SLTIU:   begin alu_op_o = ALU_SLT;     cls_o = CLS_I;      end
            OP_LUI:     begin alu_op_o = ALU_LUI;     cls_o = CLS_I;      end
            OP_B:       begin alu_op_o = ALU_B;       cls_o = CLS_BRANCH; end
            OP_BEQ:     begin alu_op_o = ALU_BEQ;     cls_o = CLS_BRANCH; end
            OP_BGEZ:    begin alu_op_o = ALU_BGEZ;    cls_o = CLS_BRANCH; end
            OP_BNE:     begin alu_op_o = ALU_BNE;     cls_o = CLS_BRANCH; end
            OP_J:       begin alu_op_o = ALU_ADD;     cls_o = CLS_JUMP;   end
            default:    ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-style sequencer sharing one ALU and one memory port.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to halt on unlisted opcodes; otherwise they retire as NOPs.
module multicycle_ctrl
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [CNT_W-1:0]    instr_retired,
    output logic                illegal_op
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                retire;
    logic [OPCODE_W-1:0] dec_op;
    logic [ALU_OP_W-1:0] dec_alu_op;
    cls_e                dec_cls;

    // DECODE dispatches on the live opcode; later states use the latched copy.
    assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

    alu_op_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_op_decode (
        .op_i     (dec_op),
        .alu_op_o (dec_alu_op),
        .cls_o    (dec_cls)
    );

    assign retired_d     = retired_q + CNT_W'(retire);
    assign instr_retired = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`endif

        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // PC+4 and IR load only once the instruction word is actually back.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d      = opcode;
                alu_src_b = SRCB_IMM_SH2;
                case (dec_cls)
                    CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
                    CLS_R:               state_d = S_EXEC_R;
                    CLS_I:               state_d = S_EXEC_I;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    CLS_JUMP:            state_d = S_JUMP;
                    default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d = S_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (dec_cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_op    = dec_alu_op;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_alu_op;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (dec_cls == CLS_R);
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_B;
                alu_op        = dec_alu_op;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-state control vectors, memory waits,
// retire counting, asynchronous reset mid-instruction and illegal-opcode handling.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  pc_source, alu_src_b;
    logic [3:0]  alu_op;
    logic [31:0] instr_retired;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    multicycle_ctrl #(.OPCODE_W(6), .ALU_OP_W(4), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_retired (instr_retired),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    logic [17:0] ctl;
    assign ctl = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

    function automatic logic [17:0] cv(input logic pw, pwc, input logic [1:0] ps,
                                       input logic irw, iod, mr, mw, m2r, rd, rw, asa,
                                       input logic [1:0] asb, input logic [3:0] aop);
        return {pw, pwc, ps, irw, iod, mr, mw, m2r, rd, rw, asa, asb, aop};
    endfunction

    localparam logic [17:0] V_ZERO    = 18'h0;
    localparam logic [17:0] V_FWAIT   = cv(0,0,2'b00,0,0,1,0,0,0,0,0,2'b01,4'b0000);
    localparam logic [17:0] V_FRDY    = cv(1,0,2'b00,1,0,1,0,0,0,0,0,2'b01,4'b0000);
    localparam logic [17:0] V_DEC     = cv(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,4'b0000);
    localparam logic [17:0] V_EXI_ADD = cv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0000);
    localparam logic [17:0] V_EXI_ORI = cv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0101);
    localparam logic [17:0] V_EXR_R   = cv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,4'b0010);
    localparam logic [17:0] V_EXR_BS  = cv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,4'b1111);
    localparam logic [17:0] V_WB_I    = cv(0,0,2'b00,0,0,0,0,0,0,1,0,2'b00,4'b0000);
    localparam logic [17:0] V_WB_R    = cv(0,0,2'b00,0,0,0,0,0,1,1,0,2'b00,4'b0000);
    localparam logic [17:0] V_MADDR   = cv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0000);
    localparam logic [17:0] V_MRD     = cv(0,0,2'b00,0,1,1,0,0,0,0,0,2'b00,4'b0000);
    localparam logic [17:0] V_MWB     = cv(0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,4'b0000);
    localparam logic [17:0] V_MWR     = cv(0,0,2'b00,0,1,0,1,0,0,0,0,2'b00,4'b0000);
    localparam logic [17:0] V_BEQ     = cv(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b0001);
    localparam logic [17:0] V_BNE     = cv(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b1011);
    localparam logic [17:0] V_JMP     = cv(1,0,2'b10,0,0,0,0,0,0,0,0,2'b00,4'b0000);

    logic [5:0]  b2b_op  [4];
    logic [17:0] b2b_exp [4][4];
    int          b2b_len [4];

    initial begin
        b2b_op[0] = 6'b000000; b2b_len[0] = 4;
        b2b_op[1] = 6'b011111; b2b_len[1] = 4;
        b2b_op[2] = 6'b001101; b2b_len[2] = 4;
        b2b_op[3] = 6'b000101; b2b_len[3] = 3;
        b2b_exp[0] = '{V_FRDY, V_DEC, V_EXR_R,   V_WB_R};
        b2b_exp[1] = '{V_FRDY, V_DEC, V_EXR_BS,  V_WB_R};
        b2b_exp[2] = '{V_FRDY, V_DEC, V_EXI_ORI, V_WB_I};
        b2b_exp[3] = '{V_FRDY, V_DEC, V_BNE,     V_ZERO};
    end

    task automatic test_reset;
        #2 rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'd0;
        repeat (2) @(negedge clk);
        n_tests++; if (ctl !== V_ZERO) begin n_fail++; $display("FAIL reset_ctl: got %h want %h", ctl, V_ZERO); end
        n_tests++; if (instr_retired !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", instr_retired); end
        n_tests++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (ctl !== V_ZERO) begin n_fail++; $display("FAIL init_ctl: got %h want %h", ctl, V_ZERO); end
        @(negedge clk);
        exp_cnt = 0;
    endtask

    task automatic test_addi;
        logic [17:0] seq [4];
        seq = '{V_FRDY, V_DEC, V_EXI_ADD, V_WB_I};
        opcode = 6'b001000;
        mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (ctl !== seq[i]) begin n_fail++; $display("FAIL addi[%0d]: got %h want %h", i, ctl, seq[i]); end
            @(negedge clk);
        end
        exp_cnt++;
        n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL addi_cnt: got %0d want %0d", instr_retired, exp_cnt); end
    endtask

    task automatic test_lw_wait;
        int cyc = 0;
        int irw = 0;
        opcode = 6'b100011;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (ctl !== V_FWAIT) begin n_fail++; $display("FAIL lw_fetch_wait[%0d]: got %h want %h", i, ctl, V_FWAIT); end
            irw += int'(ir_write);
            @(negedge clk); cyc++;
        end
        mem_ready = 1'b1;
        #1;
        n_tests++; if (ctl !== V_FRDY) begin n_fail++; $display("FAIL lw_fetch_rdy: got %h want %h", ctl, V_FRDY); end
        irw += int'(ir_write);
        @(negedge clk); cyc++;
        n_tests++; if (ctl !== V_DEC) begin n_fail++; $display("FAIL lw_decode: got %h want %h", ctl, V_DEC); end
        mem_ready = 1'b0;
        @(negedge clk); cyc++;
        n_tests++; if (ctl !== V_MADDR) begin n_fail++; $display("FAIL lw_mem_addr: got %h want %h", ctl, V_MADDR); end
        @(negedge clk); cyc++;
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (ctl !== V_MRD) begin n_fail++; $display("FAIL lw_mem_rd_wait[%0d]: got %h want %h", i, ctl, V_MRD); end
            @(negedge clk); cyc++;
        end
        mem_ready = 1'b1;
        #1;
        n_tests++; if (ctl !== V_MRD) begin n_fail++; $display("FAIL lw_mem_rd_rdy: got %h want %h", ctl, V_MRD); end
        @(negedge clk); cyc++;
        n_tests++; if (ctl !== V_MWB) begin n_fail++; $display("FAIL lw_mem_wb: got %h want %h", ctl, V_MWB); end
        @(negedge clk); cyc++;
        n_tests++; if (ctl !== V_FRDY) begin n_fail++; $display("FAIL lw_next_fetch: got %h want %h after %0d cycles", ctl, V_FRDY, cyc); end
        n_tests++; if (irw !== 1) begin n_fail++; $display("FAIL lw_ir_write_pulses: got %0d want 1", irw); end
        exp_cnt++;
        n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL lw_cnt: got %0d want %0d", instr_retired, exp_cnt); end
    endtask

    task automatic test_sw_beq;
        logic [17:0] sseq [3];
        logic [17:0] bseq [3];
        sseq = '{V_FRDY, V_DEC, V_MADDR};
        bseq = '{V_FRDY, V_DEC, V_BEQ};
        opcode = 6'b101011;
        mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (ctl !== sseq[i]) begin n_fail++; $display("FAIL sw[%0d]: got %h want %h", i, ctl, sseq[i]); end
            @(negedge clk);
        end
        n_tests++; if (ctl !== V_MWR) begin n_fail++; $display("FAIL sw_mem_wr: got %h want %h", ctl, V_MWR); end
        n_tests++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL sw_reg_write: got %b want 0", reg_write); end
        @(negedge clk);
        exp_cnt++;
        n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL sw_cnt: got %0d want %0d", instr_retired, exp_cnt); end
        opcode = 6'b000100;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (ctl !== bseq[i]) begin n_fail++; $display("FAIL beq[%0d]: got %h want %h", i, ctl, bseq[i]); end
            @(negedge clk);
        end
        exp_cnt++;
        n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL beq_cnt: got %0d want %0d", instr_retired, exp_cnt); end
    endtask

    task automatic test_jump;
        logic [17:0] seq [3];
        seq = '{V_FRDY, V_DEC, V_JMP};
        opcode = 6'b000010;
        mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (ctl !== seq[i]) begin n_fail++; $display("FAIL jump[%0d]: got %h want %h", i, ctl, seq[i]); end
            @(negedge clk);
        end
        n_tests++; if (ctl !== V_FRDY) begin n_fail++; $display("FAIL jump_back_to_fetch: got %h want %h", ctl, V_FRDY); end
        exp_cnt++;
        n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL jump_cnt: got %0d want %0d", instr_retired, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            opcode = b2b_op[k];
            #1;
            for (int i = 0; i < b2b_len[k]; i++) begin
                n_tests++;
                if (ctl !== b2b_exp[k][i]) begin
                    n_fail++; $display("FAIL b2b_op%0d[%0d]: got %h want %h", k, i, ctl, b2b_exp[k][i]);
                end
                @(negedge clk);
            end
            exp_cnt++;
            n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt%0d: got %0d want %0d", k, instr_retired, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid;
        opcode = 6'b101011;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL mid_pre_mem_write: got %b want 1", mem_write); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL mid_async_mem_write: got %b want 0", mem_write); end
        n_tests++; if (ctl !== V_ZERO) begin n_fail++; $display("FAIL mid_async_ctl: got %h want %h", ctl, V_ZERO); end
        n_tests++; if (instr_retired !== 32'd0) begin n_fail++; $display("FAIL mid_async_cnt: got %0d want 0", instr_retired); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_tests++; if (ctl !== V_ZERO) begin n_fail++; $display("FAIL mid_init_ctl: got %h want %h", ctl, V_ZERO); end
        @(negedge clk);
        n_tests++; if (ctl !== V_FRDY) begin n_fail++; $display("FAIL mid_restart_fetch: got %h want %h", ctl, V_FRDY); end
        exp_cnt = 0;
    endtask

    task automatic test_illegal;
        opcode = 6'b111111;
        mem_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (ctl !== V_DEC) begin n_fail++; $display("FAIL ill_decode: got %h want %h", ctl, V_DEC); end
        @(negedge clk);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ctl !== V_ZERO || illegal_op !== 1'b1 || pc_write !== 1'b0) begin
                n_fail++; $display("FAIL ill_halt[%0d]: got ctl=%h ill=%b want ctl=%h ill=1", i, ctl, illegal_op, V_ZERO);
            end
            @(negedge clk);
        end
        n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL ill_cnt: got %0d want %0d", instr_retired, exp_cnt); end
`else
        n_tests++; if (ctl !== V_FRDY) begin n_fail++; $display("FAIL ill_nop_fetch: got %h want %h", ctl, V_FRDY); end
        n_tests++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_flag: got %b want 0", illegal_op); end
        exp_cnt++;
        n_tests++; if (instr_retired !== 32'(exp_cnt)) begin n_fail++; $display("FAIL ill_cnt: got %0d want %0d", instr_retired, exp_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_sw_beq();
        test_jump();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
